// File: rtl/point_scanner.sv
// point_scanner: reads one frame out of the point RAM and hands each point to the DAC driver.
// It covers the RAM's one-cycle read latency, holds each point for a programmable dwell, and
// repeats the frame a programmable number of times. When the frame set is finished it pulses
// done_drawing so the buffer can return to its receive state.
//
// DAC handshake: dac_valid rises with new dac_x/dac_y/dac_z. All three hold steady until a
// cycle where dac_valid and dac_ready are both high. That rising edge is the transfer.
// dac_valid drops on that same edge. An abort (drawing low) overrides the handshake.
module point_scanner #(
    parameter int IDX_W   = 11,
    parameter int DWELL_W = 16,
    parameter int REP_W   = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               drawing,
    input  logic [IDX_W-1:0]   num_pts,
    input  logic [24:0]        point,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [REP_W-1:0]   repeats,
    input  logic               dac_ready,
    output logic [IDX_W-1:0]   index,
    output logic               done_drawing,
    output logic [11:0]        dac_x,
    output logic [11:0]        dac_y,
    output logic               dac_z,
    output logic               dac_valid,
    output logic               busy,
    output logic [2:0]         state_o
);

    // Encoding is visible on state_o for debug/checkers.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        LOAD    = 3'd2,
        SEND    = 3'd3,
        DWELL   = 3'd4,
        DONE    = 3'd5,
        RELEASE = 3'd6
    } state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   index_q;
    logic [IDX_W-1:0]   n_q;        // points per frame, latched at start
    logic [REP_W-1:0]   r_q;        // frames to draw, never 0
    logic [REP_W-1:0]   f_q;        // current frame number
    logic [DWELL_W-1:0] cnt_q;      // dwell cycles remaining for this point
    logic [11:0]        dac_x_q;
    logic [11:0]        dac_y_q;
    logic               dac_z_q;
    logic               dac_valid_q;
    logic               done_q;
    logic               busy_q;
    logic               abort;

    // The buffer withdrew the frame while a point was in flight.
    assign abort = !drawing &&
                   (state_q == FETCH || state_q == LOAD || state_q == SEND || state_q == DWELL);

    // Sequencer: single registered FSM, all outputs registered alongside the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            index_q     <= '0;
            n_q         <= '0;
            r_q         <= '0;
            f_q         <= '0;
            cnt_q       <= '0;
            dac_x_q     <= '0;
            dac_y_q     <= '0;
            dac_z_q     <= 1'b0;
            dac_valid_q <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            // done_drawing is high only in the cycle spent in DONE.
            done_q <= 1'b0;
            if (abort) begin
                state_q     <= IDLE;
                index_q     <= '0;
                dac_z_q     <= 1'b0;
                dac_valid_q <= 1'b0;
                busy_q      <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        index_q     <= '0;
                        dac_z_q     <= 1'b0;
                        dac_valid_q <= 1'b0;
                        if (drawing) begin
                            n_q    <= num_pts;
                            r_q    <= (repeats == '0) ? REP_W'(1) : repeats;
                            f_q    <= '0;
                            busy_q <= 1'b1;
                            if (num_pts == '0) begin
                                state_q <= DONE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= FETCH;
                            end
                        end
                    end
                    // Address cycle: index is already stable, RAM data arrives next cycle.
                    FETCH: begin
                        state_q <= LOAD;
                    end
                    LOAD: begin
                        dac_z_q     <= point[24];
                        dac_x_q     <= point[23:12];
                        dac_y_q     <= point[11:0];
                        dac_valid_q <= 1'b1;
                        cnt_q       <= dwell;
                        state_q     <= SEND;
                    end
                    SEND: begin
                        if (dac_ready) begin
                            dac_valid_q <= 1'b0;
                            state_q     <= DWELL;
                        end
                    end
                    DWELL: begin
                        if (cnt_q != '0) begin
                            cnt_q <= cnt_q - 1'b1;
                        end else begin
                            // The beam is blanked between points and after the last one.
                            dac_z_q <= 1'b0;
                            if (index_q != n_q - 1'b1) begin
                                index_q <= index_q + 1'b1;
                                state_q <= FETCH;
                            end else if (f_q != r_q - 1'b1) begin
                                f_q     <= f_q + 1'b1;
                                index_q <= '0;
                                state_q <= FETCH;
                            end else begin
                                index_q <= '0;
                                done_q  <= 1'b1;
                                state_q <= DONE;
                            end
                        end
                    end
                    DONE: begin
                        index_q <= '0;
                        dac_z_q <= 1'b0;
                        state_q <= RELEASE;
                    end
                    // A stale drawing level must not start a second frame set.
                    RELEASE: begin
                        if (!drawing) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign index        = index_q;
    assign done_drawing = done_q;
    assign dac_x        = dac_x_q;
    assign dac_y        = dac_y_q;
    assign dac_z        = dac_z_q;
    assign dac_valid    = dac_valid_q;
    assign busy         = busy_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_point_scanner.sv
// Directed testbench for point_scanner. A small RAM model feeds the read port. A negedge
// monitor logs every DAC transfer and every done pulse. The checks run as directed steps.
module tb_point_scanner;

    localparam int IDX_W   = 11;
    localparam int DWELL_W = 16;
    localparam int REP_W   = 4;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SEND    = 3'd3;
    localparam logic [2:0] S_DWELL   = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;
    localparam logic [2:0] S_RELEASE = 3'd6;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset_n;
    logic               drawing;
    logic [IDX_W-1:0]   num_pts;
    logic [24:0]        point;
    logic [DWELL_W-1:0] dwell;
    logic [REP_W-1:0]   repeats;
    logic               dac_ready;
    logic [IDX_W-1:0]   index;
    logic               done_drawing;
    logic [11:0]        dac_x;
    logic [11:0]        dac_y;
    logic               dac_z;
    logic               dac_valid;
    logic               busy;
    logic [2:0]         state_o;

    point_scanner #(.IDX_W(IDX_W), .DWELL_W(DWELL_W), .REP_W(REP_W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .drawing      (drawing),
        .num_pts      (num_pts),
        .point        (point),
        .dwell        (dwell),
        .repeats      (repeats),
        .dac_ready    (dac_ready),
        .index        (index),
        .done_drawing (done_drawing),
        .dac_x        (dac_x),
        .dac_y        (dac_y),
        .dac_z        (dac_z),
        .dac_valid    (dac_valid),
        .busy         (busy),
        .state_o      (state_o)
    );

    // Point RAM with a one-cycle registered read.
    logic [24:0] mem [0:15];
    always @(posedge clk) point <= mem[index[3:0]];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    logic [24:0]      exp_q[$];
    logic [24:0]      obs_q[$];
    int               obs_cyc[$];
    logic [IDX_W-1:0] obs_idx[$];
    int               done_cnt = 0;
    int               done_cyc = 0;
    int               vec_cnt  = 0;
    int               err_cnt  = 0;
    int               start_cyc = 0;

    always @(negedge clk) begin
        if (reset_n) begin
            if (dac_valid && dac_ready) begin
                obs_q.push_back({dac_z, dac_x, dac_y});
                obs_cyc.push_back(cyc);
                obs_idx.push_back(index);
            end
            if (done_drawing) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        obs_q.delete();
        obs_cyc.delete();
        obs_idx.delete();
        exp_q.delete();
        done_cnt = 0;
    endtask

    task automatic start_frame(input int n, input int r, input int d);
        num_pts   = IDX_W'(n);
        repeats   = REP_W'(r);
        dwell     = DWELL_W'(d);
        drawing   = 1'b1;
        start_cyc = cyc;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (state_o == s) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic wait_valid(input logic lvl, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (dac_valid == lvl) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (done_drawing) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bit          ok;
        logic [24:0] pat2 [0:1];

        for (int i = 0; i < 16; i++) mem[i] = '0;
        reset_n   = 1'b0;
        drawing   = 1'b0;
        num_pts   = '0;
        dwell     = '0;
        repeats   = '0;
        dac_ready = 1'b1;

        // Reset state
        repeat (3) step();
        check("rst_index", 32'(index), 32'(0));
        check("rst_done", 32'(done_drawing), 32'(0));
        check("rst_x", 32'(dac_x), 32'(0));
        check("rst_y", 32'(dac_y), 32'(0));
        check("rst_z", 32'(dac_z), 32'(0));
        check("rst_valid", 32'(dac_valid), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_state", 32'(state_o), 32'(S_IDLE));
        reset_n = 1'b1;
        step();

        mem[0] = {1'b1, 12'hABC, 12'h123};
        mem[1] = {1'b0, 12'h001, 12'hFFF};
        mem[2] = {1'b1, 12'h800, 12'h800};

        // Reset asserted asynchronously while stalled in SEND
        dac_ready = 1'b0;
        start_frame(3, 1, 2);
        wait_state(S_SEND, 20, ok);
        check("mid_send_reached", 32'(ok), 32'(1));
        check("mid_send_x", 32'(dac_x), 32'(12'hABC));
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(dac_valid), 32'(0));
        check("async_rst_x", 32'(dac_x), 32'(0));
        check("async_rst_y", 32'(dac_y), 32'(0));
        check("async_rst_z", 32'(dac_z), 32'(0));
        check("async_rst_busy", 32'(busy), 32'(0));
        check("async_rst_state", 32'(state_o), 32'(S_IDLE));
        drawing   = 1'b0;
        dac_ready = 1'b1;
        step();
        reset_n = 1'b1;
        step();
        check("post_rst_state", 32'(state_o), 32'(S_IDLE));

        // Single frame, 3 points, dwell 2, ready tied high
        clear_log();
        exp_q.push_back({1'b1, 12'hABC, 12'h123});
        exp_q.push_back({1'b0, 12'h001, 12'hFFF});
        exp_q.push_back({1'b1, 12'h800, 12'h800});
        start_frame(3, 1, 2);
        wait_done(200, ok);
        check("f1_done_seen", 32'(ok), 32'(1));
        check("f1_done_state", 32'(state_o), 32'(S_DONE));
        step();
        check("f1_release", 32'(state_o), 32'(S_RELEASE));
        check("f1_done_one_cycle", 32'(done_drawing), 32'(0));
        drawing = 1'b0;
        step();
        check("f1_idle", 32'(state_o), 32'(S_IDLE));
        check("f1_busy_low", 32'(busy), 32'(0));
        check("f1_count", 32'(obs_q.size()), 32'(3));
        for (int i = 0; i < 3; i++) check("f1_point", 32'(obs_q[i]), 32'(exp_q[i]));
        // drawing sampled at start_cyc+1 -> FETCH, LOAD, SEND at start_cyc+3
        check("f1_first_latency", 32'(obs_cyc[0] - start_cyc), 32'(3));
        // FETCH + LOAD + SEND + 3 DWELL cycles between transfers
        check("f1_spacing_01", 32'(obs_cyc[1] - obs_cyc[0]), 32'(6));
        check("f1_spacing_12", 32'(obs_cyc[2] - obs_cyc[1]), 32'(6));
        // last SEND cycle, then 3 DWELL cycles, then DONE
        check("f1_done_timing", 32'(done_cyc - obs_cyc[2]), 32'(4));
        check("f1_done_count", 32'(done_cnt), 32'(1));

        // Repeats with backpressure on every second point
        clear_log();
        pat2[0] = {1'b0, 12'h111, 12'h222};
        pat2[1] = {1'b1, 12'h333, 12'h444};
        mem[0]  = pat2[0];
        mem[1]  = pat2[1];
        start_frame(2, 3, 1);
        for (int p = 0; p < 6; p++) begin
            wait_valid(1'b1, 50, ok);
            check("rp_valid_seen", 32'(ok), 32'(1));
            if (p % 2 == 1) begin
                dac_ready = 1'b0;
                repeat (5) begin
                    step();
                    check("rp_stall_hold", 32'({dac_valid, dac_z, dac_x, dac_y}),
                          32'({1'b1, pat2[1]}));
                end
                dac_ready = 1'b1;
            end
            wait_valid(1'b0, 50, ok);
            check("rp_valid_drop", 32'(ok), 32'(1));
        end
        wait_done(100, ok);
        check("rp_done_seen", 32'(ok), 32'(1));
        step();
        drawing = 1'b0;
        step();
        check("rp_idle", 32'(state_o), 32'(S_IDLE));
        check("rp_count", 32'(obs_q.size()), 32'(6));
        for (int i = 0; i < 6; i++) begin
            check("rp_index", 32'(obs_idx[i]), 32'(i % 2));
            check("rp_point", 32'(obs_q[i]), 32'(pat2[i % 2]));
        end
        check("rp_done_count", 32'(done_cnt), 32'(1));

        // Empty frame: DONE directly after IDLE
        clear_log();
        start_frame(0, 1, 0);
        step();
        check("empty_done_pulse", 32'(done_drawing), 32'(1));
        check("empty_done_state", 32'(state_o), 32'(S_DONE));
        step();
        check("empty_done_off", 32'(done_drawing), 32'(0));
        drawing = 1'b0;
        step();
        check("empty_idle", 32'(state_o), 32'(S_IDLE));
        check("empty_no_points", 32'(obs_q.size()), 32'(0));
        check("empty_done_count", 32'(done_cnt), 32'(1));

        // repeats=0 draws once; drawing held high after done must not re-trigger
        clear_log();
        mem[0] = {1'b0, 12'hFED, 12'h321};
        start_frame(1, 0, 0);
        wait_done(100, ok);
        check("zr_done_seen", 32'(ok), 32'(1));
        repeat (4) begin
            step();
            check("guard_release", 32'(state_o), 32'(S_RELEASE));
            check("guard_no_valid", 32'(dac_valid), 32'(0));
            check("guard_no_done", 32'(done_drawing), 32'(0));
        end
        drawing = 1'b0;
        step();
        check("guard_idle", 32'(state_o), 32'(S_IDLE));
        check("zr_count", 32'(obs_q.size()), 32'(1));
        check("zr_point", 32'(obs_q[0]), 32'({1'b0, 12'hFED, 12'h321}));
        check("zr_done_count", 32'(done_cnt), 32'(1));

        // Abort in the DWELL of the fifth point of ten
        clear_log();
        for (int i = 0; i < 10; i++) mem[i] = {1'b1, 12'(16 + i), 12'(32 + i)};
        start_frame(10, 1, 3);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (state_o == S_DWELL && index == 11'd4) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        check("ab_reach_dwell5", 32'(ok), 32'(1));
        check("ab_z_before", 32'(dac_z), 32'(1));
        check("ab_points_before", 32'(obs_q.size()), 32'(5));
        drawing = 1'b0;
        step();
        check("ab_state", 32'(state_o), 32'(S_IDLE));
        check("ab_z", 32'(dac_z), 32'(0));
        check("ab_index", 32'(index), 32'(0));
        check("ab_valid", 32'(dac_valid), 32'(0));
        check("ab_busy", 32'(busy), 32'(0));
        repeat (5) step();
        check("ab_no_done", 32'(done_cnt), 32'(0));
        clear_log();
        start_frame(10, 1, 3);
        wait_valid(1'b1, 50, ok);
        check("ab_restart_seen", 32'(ok), 32'(1));
        check("ab_restart_index", 32'(index), 32'(0));
        check("ab_restart_point", 32'({dac_z, dac_x, dac_y}), 32'({1'b1, 12'h010, 12'h020}));
        drawing = 1'b0;
        step();
        check("ab_final_idle", 32'(state_o), 32'(S_IDLE));

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
